// File: rtl/core_pkg.sv
// Shared phase, next-PC source and error encodings for the multi-cycle core.
// Decode and datapath compare against these constants rather than raw literals.
package core_pkg;

  typedef enum logic [2:0] {
    PH_FETCH  = 3'd0,
    PH_DECODE = 3'd1,
    PH_EXEC   = 3'd2,
    PH_MEM    = 3'd3,
    PH_WRITE  = 3'd4,
    PH_IDLE   = 3'd5,
    PH_HALT   = 3'd6
  } phase_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_REL = 2'd1,
    PC_ABS = 2'd2
  } pc_sel_t;

  typedef logic [1:0] err_t;
  localparam err_t ERR_NONE    = 2'd0;
  localparam err_t ERR_ILLEGAL = 2'd1;
  localparam err_t ERR_IMEM_TO = 2'd2;
  localparam err_t ERR_DMEM_TO = 2'd3;

  // Phases that belong to instruction execution (counted as core cycles).
  function automatic logic is_active(input phase_t p);
    return (p == PH_FETCH) || (p == PH_DECODE) || (p == PH_EXEC) ||
           (p == PH_MEM) || (p == PH_WRITE);
  endfunction

endpackage

// File: rtl/phase_sequencer_wait_timer.sv
// Cycle counter for memory-handshake waits; expired flags the LIMIT-th waiting cycle.
// LIMIT = 0 disables expiry entirely.
module wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic en,
  output logic expired
);

  localparam int TW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [TW-1:0] LAST = TW'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (LIMIT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/phase_sequencer.sv
// Master control FSM of the multi-cycle core: phase sequencing, memory handshakes,
// next-PC selection, writeback gating, cycle/instret counters and halt/error handling.
module phase_sequencer
  import core_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic             halt_req,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             branch_c,
  input  logic             branch_uc,
  input  logic             branch_relative,
  input  logic             cond_true,
  input  logic             illegal,
  output logic [2:0]       state,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             retire,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  phase_t state_q;
  phase_t state_nxt;
  err_t   err_q;
  err_t   err_val;
  logic   err_set;
  logic   halt_q;
  logic   tmr_start;
  logic   tmr_en;
  logic   tmr_expired;
  logic   in_write;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= PH_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = PH_IDLE;
    err_set   = 1'b0;
    err_val   = ERR_NONE;
    case (state_q)
      PH_IDLE:   state_nxt = run ? PH_FETCH : PH_IDLE;
      PH_FETCH: begin
        // A ready in the expiry cycle still completes the fetch.
        if (imem_ready) begin
          state_nxt = PH_DECODE;
        end else if (tmr_expired) begin
          state_nxt = PH_HALT;
          err_set   = 1'b1;
          err_val   = ERR_IMEM_TO;
        end else begin
          state_nxt = PH_FETCH;
        end
      end
      PH_DECODE: state_nxt = PH_EXEC;
      PH_EXEC: begin
        if (illegal) begin
          state_nxt = PH_HALT;
          err_set   = 1'b1;
          err_val   = ERR_ILLEGAL;
        end else if (mem_read || mem_write) begin
          state_nxt = PH_MEM;
        end else begin
          state_nxt = PH_WRITE;
        end
      end
      PH_MEM: begin
        if (dmem_ready) begin
          state_nxt = PH_WRITE;
        end else if (tmr_expired) begin
          state_nxt = PH_HALT;
          err_set   = 1'b1;
          err_val   = ERR_DMEM_TO;
        end else begin
          state_nxt = PH_MEM;
        end
      end
      PH_WRITE: begin
        if (halt_q || halt_req) begin
          state_nxt = PH_HALT;
        end else if (!run) begin
          state_nxt = PH_IDLE;
        end else begin
          state_nxt = PH_FETCH;
        end
      end
      PH_HALT:   state_nxt = run ? PH_HALT : PH_IDLE;
      default:   state_nxt = PH_IDLE;
    endcase
  end

  assign tmr_start = ((state_nxt == PH_FETCH) && (state_q != PH_FETCH)) ||
                     ((state_nxt == PH_MEM) && (state_q != PH_MEM));
  assign tmr_en    = (state_q == PH_FETCH) || (state_q == PH_MEM);

  wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rstn   (rstn),
    .start  (tmr_start),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  // Halt requests wait for the current instruction to retire.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halt_q <= 1'b0;
    end else if ((state_nxt == PH_HALT) && (state_q != PH_HALT)) begin
      halt_q <= 1'b0;
    end else if (halt_req && is_active(state_q)) begin
      halt_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= ERR_NONE;
    end else if (err_set) begin
      err_q <= err_val;
    end else if ((state_q == PH_IDLE) && (state_nxt == PH_FETCH)) begin
      err_q <= ERR_NONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (is_active(state_q)) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
      if (in_write) begin
        instret_cnt <= instret_cnt + 1'b1;
      end
    end
  end

  assign in_write = (state_q == PH_WRITE);
  assign state    = state_q;
  assign imem_req = (state_q == PH_FETCH);
  assign dmem_req = (state_q == PH_MEM);
  assign halted   = (state_q == PH_HALT);
  assign err_code = err_q;
  assign ir_we    = (state_q == PH_FETCH) && imem_ready;
  assign rf_we    = in_write && reg_write && (err_q == ERR_NONE);
  assign pc_we    = in_write;
  assign retire   = in_write;

  always_comb begin
    pc_sel = PC_SEQ;
    if (in_write) begin
      if (branch_uc && !branch_relative) begin
        pc_sel = PC_ABS;
      end else if (branch_uc || (branch_c && cond_true)) begin
        pc_sel = PC_REL;
      end
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed scenarios with literal expectations followed by a randomized run,
// all checked every cycle against a cycle-level reference model of the sequencer rules.
module tb_phase_sequencer;

  localparam int CW = 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rstn, run, halt_req, imem_ready, dmem_ready;
  logic mem_read, mem_write, reg_write, branch_c, branch_uc, branch_relative;
  logic cond_true, illegal;
  logic [2:0] state;
  logic imem_req, ir_we, dmem_req, rf_we, pc_we, retire, halted;
  logic [1:0] pc_sel, err_code;
  logic [CW-1:0] cycle_cnt, instret_cnt;

  int n_chk = 0;
  int n_fail = 0;

  phase_sequencer #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .run(run), .halt_req(halt_req),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .branch_c(branch_c), .branch_uc(branch_uc), .branch_relative(branch_relative),
    .cond_true(cond_true), .illegal(illegal),
    .state(state), .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire),
    .halted(halted), .err_code(err_code),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: phase number, cycles already waited, error, halt pending, counters.
  int  m_st, m_wait, m_err, m_cyc, m_ret, nst, e_sel;
  bit  m_pend, wr;

  always @(negedge clk) begin
    if (!rstn) begin
      m_st = 5; m_wait = 0; m_err = 0; m_cyc = 0; m_ret = 0; m_pend = 0;
    end
    wr = (m_st == 4);
    chk("m_state", int'(state), m_st);
    chk("m_imem_req", int'(imem_req), int'(m_st == 0));
    chk("m_ir_we", int'(ir_we), int'(m_st == 0 && imem_ready));
    chk("m_dmem_req", int'(dmem_req), int'(m_st == 3));
    chk("m_rf_we", int'(rf_we), int'(wr && reg_write));
    chk("m_pc_we", int'(pc_we), int'(wr));
    chk("m_retire", int'(retire), int'(wr));
    chk("m_halted", int'(halted), int'(m_st == 6));
    chk("m_err_code", int'(err_code), m_err);
    chk("m_cycle_cnt", int'(cycle_cnt), m_cyc);
    chk("m_instret_cnt", int'(instret_cnt), m_ret);
    if (wr) begin
      if (branch_uc && !branch_relative) e_sel = 2;
      else if (branch_uc || (branch_c && cond_true)) e_sel = 1;
      else e_sel = 0;
      chk("m_pc_sel", int'(pc_sel), e_sel);
    end
    if (rstn) begin
      nst = m_st;
      case (m_st)
        5: if (run) begin nst = 0; m_err = 0; m_wait = 0; end
        0: begin
          if (imem_ready) nst = 1;
          else if (TO != 0 && m_wait + 1 == TO) begin nst = 6; m_err = 2; end
          else m_wait++;
        end
        1: nst = 2;
        2: begin
          if (illegal) begin nst = 6; m_err = 1; end
          else if (mem_read || mem_write) begin nst = 3; m_wait = 0; end
          else nst = 4;
        end
        3: begin
          if (dmem_ready) nst = 4;
          else if (TO != 0 && m_wait + 1 == TO) begin nst = 6; m_err = 3; end
          else m_wait++;
        end
        4: begin
          if (m_pend || halt_req) nst = 6;
          else if (!run) nst = 5;
          else begin nst = 0; m_wait = 0; end
        end
        6: if (!run) nst = 5;
        default: nst = 5;
      endcase
      if (m_st <= 4) m_cyc = (m_cyc + 1) % (1 << CW);
      if (wr) m_ret = (m_ret + 1) % (1 << CW);
      if (m_st <= 4 && halt_req) m_pend = 1;
      if (nst == 6 && m_st != 6) m_pend = 0;
      m_st = nst;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic clear_ctl();
    mem_read = 0; mem_write = 0; reg_write = 0; branch_c = 0; branch_uc = 0;
    branch_relative = 0; cond_true = 0; illegal = 0; halt_req = 0;
  endtask

  // Starts and ends at a FETCH sample with imem_ready=1; non-memory instruction.
  task automatic alu_instr(input bit uc, input bit rel, input bit bc, input bit ct,
                           input bit rw, input int exp_sel, input string tag);
    step(); clear_ctl();
    branch_uc = uc; branch_relative = rel; branch_c = bc; cond_true = ct; reg_write = rw;
    samp(); chk({tag, "_decode"}, int'(state), 1);
    step(); samp(); chk({tag, "_exec"}, int'(state), 2);
    step(); samp(); chk({tag, "_write"}, int'(state), 4);
    chk({tag, "_pc_sel"}, int'(pc_sel), exp_sel);
    chk({tag, "_rf_we"}, int'(rf_we), int'(rw));
    chk({tag, "_retire"}, int'(retire), 1);
    step(); samp(); chk({tag, "_fetch"}, int'(state), 0);
  endtask

  initial begin
    rstn = 0; run = 0; imem_ready = 0; dmem_ready = 0;
    clear_ctl();
    samp(); samp();
    chk("rst_state", int'(state), 5);
    chk("rst_cycle_cnt", int'(cycle_cnt), 0);
    chk("rst_imem_req", int'(imem_req), 0);
    chk("rst_halted", int'(halted), 0);

    // addi
    step(); rstn = 1; run = 1; imem_ready = 1; reg_write = 1;
    samp(); chk("addi_idle", int'(state), 5);
    step(); samp(); chk("addi_fetch", int'(state), 0); chk("addi_ir_we", int'(ir_we), 1);
    step(); samp(); chk("addi_decode", int'(state), 1);
    step(); samp(); chk("addi_exec", int'(state), 2);
    step(); samp(); chk("addi_write", int'(state), 4);
    chk("addi_rf_we", int'(rf_we), 1); chk("addi_pc_sel", int'(pc_sel), 0);
    step(); samp(); chk("addi_fetch2", int'(state), 0);
    chk("addi_instret", int'(instret_cnt), 1); chk("addi_cycles", int'(cycle_cnt), 4);

    // lw: ready arrives on the 4th MEM cycle, coinciding with timer expiry
    step(); mem_read = 1; reg_write = 1;
    samp(); chk("lw_decode", int'(state), 1);
    step(); samp(); chk("lw_exec", int'(state), 2);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) dmem_ready = 1;
      samp(); chk("lw_mem", int'(state), 3); chk("lw_dmem_req", int'(dmem_req), 1);
    end
    step(); dmem_ready = 0; mem_read = 0;
    samp(); chk("lw_write", int'(state), 4); chk("lw_rf_we", int'(rf_we), 1);
    chk("lw_err", int'(err_code), 0);
    step(); samp(); chk("lw_fetch", int'(state), 0);

    alu_instr(1, 0, 0, 0, 1, 2, "jalr");
    alu_instr(0, 1, 1, 0, 0, 0, "bge_nt");
    alu_instr(0, 1, 1, 1, 0, 1, "bge_t");

    // halt request pulsed in DECODE
    step(); clear_ctl(); reg_write = 1; halt_req = 1;
    samp(); chk("halt_decode", int'(state), 1);
    step(); halt_req = 0; samp(); chk("halt_exec", int'(state), 2);
    step(); samp(); chk("halt_write", int'(state), 4); chk("halt_retire", int'(retire), 1);
    step(); samp(); chk("halt_state", int'(state), 6); chk("halt_halted", int'(halted), 1);
    step(); run = 0; samp(); chk("halt_hold", int'(state), 6);
    step(); samp(); chk("halt_idle", int'(state), 5); chk("halt_unhalted", int'(halted), 0);

    // instruction fetch timeout
    step(); run = 1; imem_ready = 0; samp(); chk("ito_idle", int'(state), 5);
    for (int i = 0; i < 4; i++) begin
      step(); samp(); chk("ito_fetch", int'(state), 0); chk("ito_ir_we", int'(ir_we), 0);
    end
    step(); samp(); chk("ito_halt", int'(state), 6); chk("ito_err", int'(err_code), 2);

    // illegal opcode; error code sticks through IDLE and clears on the next fetch
    step(); run = 0; samp(); chk("ill_pre_halt", int'(state), 6);
    step(); samp(); chk("ill_idle", int'(state), 5); chk("ill_sticky_err", int'(err_code), 2);
    step(); run = 1; imem_ready = 1; illegal = 1; samp(); chk("ill_idle2", int'(state), 5);
    step(); samp(); chk("ill_fetch", int'(state), 0); chk("ill_err_clr", int'(err_code), 0);
    step(); samp(); chk("ill_decode", int'(state), 1);
    step(); samp(); chk("ill_exec", int'(state), 2); chk("ill_retire", int'(retire), 0);
    chk("ill_pc_we", int'(pc_we), 0);
    step(); samp(); chk("ill_halt", int'(state), 6); chk("ill_err", int'(err_code), 1);

    // asynchronous reset in the middle of MEM
    step(); run = 0; illegal = 0; samp(); chk("rm_halt", int'(state), 6);
    step(); samp(); chk("rm_idle", int'(state), 5);
    step(); run = 1; mem_write = 1; dmem_ready = 0; samp(); chk("rm_idle2", int'(state), 5);
    step(); samp(); chk("rm_fetch", int'(state), 0);
    step(); samp(); chk("rm_decode", int'(state), 1);
    step(); samp(); chk("rm_exec", int'(state), 2);
    step(); samp(); chk("rm_mem", int'(state), 3); chk("rm_dmem_req", int'(dmem_req), 1);
    step(); rstn = 0;
    samp(); chk("rm_rst_state", int'(state), 5); chk("rm_rst_dmem_req", int'(dmem_req), 0);
    chk("rm_rst_cycles", int'(cycle_cnt), 0); chk("rm_rst_instret", int'(instret_cnt), 0);
    step(); rstn = 1; mem_write = 0; samp(); chk("rm_after", int'(state), 5);

    // randomized traffic, checked by the model only
    for (int i = 0; i < 4000; i++) begin
      step();
      rstn            = ($urandom_range(0, 599) != 0);
      run             = ($urandom_range(0, 19) != 0);
      halt_req        = ($urandom_range(0, 39) == 0);
      imem_ready      = ($urandom_range(0, 2) != 0);
      dmem_ready      = ($urandom_range(0, 1) != 0);
      mem_read        = ($urandom_range(0, 3) == 0);
      mem_write       = ($urandom_range(0, 5) == 0);
      reg_write       = 1'($urandom_range(0, 1));
      branch_c        = 1'($urandom_range(0, 1));
      branch_uc       = ($urandom_range(0, 3) == 0);
      branch_relative = 1'($urandom_range(0, 1));
      cond_true       = 1'($urandom_range(0, 1));
      illegal         = ($urandom_range(0, 29) == 0);
    end
    samp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
